vram_arbiter: RTL and testbench

- Shares one single-port, synchronous-read video RAM between the VGA display fetch path and a CPU requester.
- Prefetches frame pixels in raster order into a small show-ahead FIFO, so the VGA timing generator can pop one 12-bit RGB pixel per clock while its read strobe is high.
- Grants the CPU every memory cycle the display fetch does not need, mainly horizontal and vertical blanking.
- Sits between the VGA timing generator, the VRAM and the CPU bus bridge; runs on the 25 MHz pixel clock.

---
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous-read VRAM between a raster-order display
// prefetch FIFO (strict priority) and a CPU requester that fills the idle slots.
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              vga_read,
  output logic [DATA_W-1:0] vga_data,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FRAME_C = ADDR_W'(FRAME_PIXELS);

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic              fetch_inflight_q, fetch_inflight_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              fetch_go;
  logic              cpu_grant;
  logic [CNT_W:0]    occupancy;

  // CPU handshake: cpu_req is held with stable cpu_we/addr/wdata until cpu_ack;
  // cpu_ack is a single-cycle pulse one cycle after the grant, and a request
  // still high during its ack cycle is not granted again.
  assign fifo_empty = (count_q == '0);
  assign pop        = vga_read & ~fifo_empty & ~frame_start;
  assign push       = fetch_inflight_q & ~frame_start;
  // Slots already claimed once this cycle's pop is taken into account.
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, fetch_inflight_q}
                    - {{CNT_W{1'b0}}, pop};
  assign fetch_go   = ~rst & ~frame_start & (fetch_ptr_q < FRAME_C)
                    & (occupancy < DEPTH_C);
  assign cpu_grant  = ~rst & ~fetch_go & cpu_req & ~cpu_ack_q;

  always_comb begin
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_go) begin
      mem_rd   = 1'b1;
      mem_addr = fetch_ptr_q;
    end else if (cpu_grant) begin
      mem_rd    = ~cpu_we;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    if (frame_start) begin
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fetch_ptr_d = '0;
    end else begin
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      fetch_ptr_d = fetch_ptr_q + ADDR_W'(fetch_go);
    end
    fetch_inflight_d = fetch_go;
    cpu_ack_d        = cpu_grant;
    cpu_rd_d         = cpu_grant & ~cpu_we;
    underflow_d      = underflow_q | (vga_read & fifo_empty & ~frame_start);
    cpu_rdata_d      = (cpu_ack_q & cpu_rd_q) ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      fetch_ptr_q      <= '0;
      fetch_inflight_q <= 1'b0;
      cpu_ack_q        <= 1'b0;
      cpu_rd_q         <= 1'b0;
      underflow_q      <= 1'b0;
      cpu_rdata_q      <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= mem_rdata;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      fetch_ptr_q      <= fetch_ptr_d;
      fetch_inflight_q <= fetch_inflight_d;
      cpu_ack_q        <= cpu_ack_d;
      cpu_rd_q         <= cpu_rd_d;
      underflow_q      <= underflow_d;
      cpu_rdata_q      <= cpu_rdata_d;
    end
  end

  assign vga_data  = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign underflow = underflow_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_d;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, queue-based reference checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vram_arbiter;
  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int FRAME = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          vga_read = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] vga_data;
  logic          underflow;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] vram [0:(1<<AW)-1];

  int total = 0;
  int bad = 0;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .vga_read(vga_read),
    .vga_data(vga_data), .underflow(underflow), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- VRAM model ----------------
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= vram[mem_addr];
    else        mem_rdata <= DW'($urandom);
  end

  // ---------------- reference model + compare ----------------
  logic [DW-1:0] mq [$];
  bit            m_infl = 0;
  int            m_infl_addr = 0;
  int            m_ptr = 0;
  bit            m_uf = 0;
  bit            m_ack = 0;
  bit            m_ack_rd = 0;
  int            m_ack_addr = 0;
  logic [DW-1:0] m_hold = '0;
  int            m_sz;
  bit            m_pop, m_go, m_grant;
  logic [DW-1:0] e_rdata, e_head;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      mq.delete();
      m_infl = 0; m_ptr = 0; m_uf = 0; m_ack = 0; m_ack_rd = 0; m_hold = '0;
    end else begin
      m_sz = mq.size();
      e_head = '0;
      if (m_sz > 0) e_head = mq[0];
      chk("m_vga_data", 32'(vga_data), 32'(e_head));
      chk("m_underflow", 32'(underflow), 32'(m_uf));
      chk("m_cpu_ack", 32'(cpu_ack), 32'(m_ack));
      e_rdata = (m_ack && m_ack_rd) ? vram[m_ack_addr] : m_hold;
      chk("m_cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
      m_pop   = vga_read && (m_sz > 0) && !frame_start;
      m_go    = (m_ptr < FRAME) && (m_sz + int'(m_infl) - int'(m_pop) < DEPTH) && !frame_start;
      m_grant = !m_go && cpu_req && !m_ack;
      e_addr  = m_go ? AW'(m_ptr) : (m_grant ? cpu_addr : '0);
      e_wdata = (m_grant && !m_go) ? cpu_wdata : '0;
      chk("m_mem_rd", 32'(mem_rd), 32'(m_go || (m_grant && !cpu_we)));
      chk("m_mem_we", 32'(mem_we), 32'(m_grant && cpu_we));
      chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("m_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      // advance the model to the state after the coming edge
      m_hold = e_rdata;
      if (vga_read && m_sz == 0 && !frame_start) m_uf = 1;
      if (frame_start) begin
        mq.delete();
        m_ptr = 0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(vram[m_infl_addr]);
      end
      m_infl      = m_go;
      m_infl_addr = m_ptr;
      if (m_go) m_ptr++;
      m_ack      = m_grant;
      m_ack_rd   = m_grant && !cpu_we;
      m_ack_addr = int'(cpu_addr);
    end
  end

  // ---------------- stimulus ----------------
  int  we_cnt, we_cyc, rd_n, max_addr, pct, fsr;
  bit  done, ack_seen;

  initial begin
    for (int a = 0; a < (1 << AW); a++) vram[a] = DW'(a);

    // reset, then a pop from an empty FIFO
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("rst_hold_mem_rd", 32'(mem_rd), 0);
    end
    cyc();
    rst = 1'b0;
    vga_read = 1'b1;
    @(negedge clk);
    chk("post_rst_vga_data", 32'(vga_data), 0);
    chk("post_rst_underflow", 32'(underflow), 0);
    chk("post_rst_cpu_ack", 32'(cpu_ack), 0);
    chk("post_rst_cpu_rdata", 32'(cpu_rdata), 0);
    cyc();
    vga_read = 1'b0;
    @(negedge clk);
    chk("uf_set", 32'(underflow), 1);
    chk("uf_vga_data", 32'(vga_data), 0);
    repeat (4) cyc();
    @(negedge clk);
    chk("uf_sticky", 32'(underflow), 1);
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    chk("uf_cleared", 32'(underflow), 0);
    chk("fs_no_fetch", 32'(mem_rd), 0);

    // initial fill: 8 reads at 0..7, then idle
    for (int i = 0; i < 12; i++) begin
      cyc();
      frame_start = 1'b0;
      @(negedge clk);
      if (i < 8) begin
        chk("fill_rd", 32'(mem_rd), 1);
        chk("fill_addr", 32'(mem_addr), 32'(i));
      end else begin
        chk("fill_idle", 32'(mem_rd), 0);
      end
    end
    chk("fill_head", 32'(vga_data), 0);

    // 640-pixel burst with a CPU write held pending
    cyc();
    vga_read = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h12345; cpu_wdata = 12'hABC;
    we_cnt = 0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      chk("burst_data", 32'(vga_data), 32'(DW'(i)));
      chk("burst_rd", 32'(mem_rd), 1);
      if (mem_we) we_cnt++;
      cyc();
    end
    chk("burst_no_grant", 32'(we_cnt), 0);
    chk("burst_uf", 32'(underflow), 0);
    vga_read = 1'b0;
    done = 0;
    we_cyc = -1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cyc = n;
        chk("wr_addr", 32'(mem_addr), 32'h12345);
        chk("wr_data", 32'(mem_wdata), 32'hABC);
      end
      if (cpu_ack) begin
        done = 1;
        chk("wr_ack_latency", 32'(n), 32'(we_cyc + 1));
        chk("wr_ack_no_regrant", 32'(mem_we), 0);
      end else begin
        cyc();
      end
    end
    chk("wr_ack_seen", 32'(done), 1);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("wr_vram", 32'(vram[19'h12345]), 32'hABC);

    // CPU read during blanking with a full FIFO
    repeat (6) cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
    @(negedge clk);
    chk("rd_grant", 32'(mem_rd), 1);
    chk("rd_addr", 32'(mem_addr), 32'h10);
    chk("rd_ack_early", 32'(cpu_ack), 0);
    cyc();
    @(negedge clk);
    chk("rd_ack", 32'(cpu_ack), 1);
    chk("rd_data", 32'(cpu_rdata), 32'h010);
    chk("rd_no_regrant", 32'(mem_rd), 0);
    cyc();
    cpu_req = 1'b0; cpu_addr = '0;
    @(negedge clk);
    chk("rd_ack_once", 32'(cpu_ack), 0);
    chk("rd_hold", 32'(cpu_rdata), 32'h010);

    // frame_start with count=5 and a fetch (address 5) in flight
    cyc();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (6) cyc();
    frame_start = 1'b1;
    vga_read = 1'b1;
    @(negedge clk);
    chk("fs_mid_no_fetch", 32'(mem_rd), 0);
    cyc();
    frame_start = 1'b0;
    vga_read = 1'b0;
    @(negedge clk);
    chk("fs_flush_data", 32'(vga_data), 0);
    chk("fs_no_uf", 32'(underflow), 0);
    chk("fs_next_rd", 32'(mem_rd), 1);
    chk("fs_next_addr", 32'(mem_addr), 0);
    cyc();
    @(negedge clk);
    chk("fs_no_stale", 32'(vga_data), 0);
    chk("fs_next_addr2", 32'(mem_addr), 1);

    // random traffic
    ack_seen = 0;
    pct = 50;
    fsr = 100;
    for (int c = 0; c < 8000; c++) begin
      cyc();
      if (c % 600 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 40;
          2: pct = 90;
          default: pct = 100;
        endcase
        fsr = ($urandom_range(0, 1) == 0) ? 100 : 3000;
      end
      rst = ($urandom_range(0, 599) == 0);
      frame_start = ($urandom_range(0, fsr - 1) == 0);
      vga_read = ($urandom_range(0, 99) < pct);
      if (cpu_req && ack_seen) begin
        cpu_req = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 2047));
        cpu_wdata = DW'($urandom);
      end
      @(negedge clk);
      ack_seen = cpu_ack;
    end

    // whole frame: exactly FRAME fetches, then fetch_ptr saturates
    cyc();
    rst = 1'b1; frame_start = 1'b0; vga_read = 1'b0; cpu_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    frame_start = 1'b1;
    rd_n = 0;
    max_addr = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      frame_start = 1'b0;
      vga_read = 1'b1;
      @(negedge clk);
      if (mem_rd) begin
        rd_n++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
    end
    chk("frame_reads", 32'(rd_n), 32'(FRAME));
    chk("frame_max_addr", 32'(max_addr), 32'(FRAME - 1));
    chk("frame_saturated", 32'(mem_rd), 0);

    cyc();
    vga_read = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
